// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Y86-style instruction fetch. Presents pc to the instruction ROM, decodes
//   the returned bytes combinationally and captures the decoded fields into
//   the F/D pipeline register on the next rising edge.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   pc           fetch address (direct register output) to the ROM
//   inst         ROM bytes, byte0 at [47:40] .. byte5 at [7:0]
//   stall        hold pc, F/D register and state
//   redirect     downstream correction (mispredict / ret), beats stall
//   redirect_pc  correction target
//   d_*          F/D register contents, meaningful only while d_valid=1
//   f_state      00 RUN, 01 HALTED, 10 ERROR
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc,
  input  logic [47:0] inst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        d_valid,
  output logic [3:0]  d_icode,
  output logic [3:0]  d_ifun,
  output logic [3:0]  d_ra,
  output logic [3:0]  d_rb,
  output logic [31:0] d_valc,
  output logic [31:0] d_valp,
  output logic [31:0] d_pred_pc,
  output logic [1:0]  f_state
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_HALTED = 2'b01,
    ST_ERROR  = 2'b10
  } state_t;

  state_t state_q, state_d;

  // Combinational decode of the bytes at pc.
  logic [3:0]  icode, ifun, ra, rb;
  logic [2:0]  len;
  logic        has_regs, is_jump, invalid;
  logic [31:0] valc, valp, pred_pc;

  // NOTE: every signal driven here gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    icode    = inst[47:44];
    ifun     = inst[43:40];
    len      = 3'd1;
    has_regs = 1'b0;
    is_jump  = 1'b0;
    invalid  = 1'b0;
    valc     = 32'h0;
    case (icode)
      4'h0, 4'h1, 4'h9:       len = 3'd1;
      4'h2, 4'h6, 4'hA, 4'hB: begin
        len      = 3'd2;
        has_regs = 1'b1;
      end
      4'h7, 4'h8: begin
        len     = 3'd5;
        is_jump = 1'b1;
        // Little-endian destination in bytes 1..4.
        valc    = {inst[15:8], inst[23:16], inst[31:24], inst[39:32]};
      end
      4'h3, 4'h4, 4'h5: begin
        len      = 3'd6;
        has_regs = 1'b1;
        // Little-endian constant in bytes 2..5.
        valc     = {inst[7:0], inst[15:8], inst[23:16], inst[31:24]};
      end
      default: invalid = 1'b1;
    endcase
    ra      = has_regs ? inst[39:36] : 4'hF;
    rb      = has_regs ? inst[35:32] : 4'hF;
    valp    = pc + {29'd0, len};
    // Calls and jumps predicted taken; ret falls through and relies on a
    // downstream redirect.
    pred_pc = is_jump ? valc : valp;
  end

  // Next-state / control.
  logic [31:0] pc_d;
  logic        valid_d;
  logic        load_fd;

  always_comb begin
    state_d = state_q;
    pc_d    = pc;
    valid_d = d_valid;
    load_fd = 1'b0;
    if (redirect) begin
      pc_d    = redirect_pc;
      valid_d = 1'b0;
      state_d = ST_RUN;
    end else if (!stall) begin
      case (state_q)
        ST_RUN: begin
          load_fd = 1'b1;
          valid_d = 1'b1;
          if (invalid) begin
            state_d = ST_ERROR;     // pc held at the faulting address
          end else if (icode == 4'h0) begin
            state_d = ST_HALTED;    // pc held at the halt address
          end else begin
            pc_d = pred_pc;
          end
        end
        default: valid_d = 1'b0;    // HALTED / ERROR emit bubbles
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      pc      <= RESET_PC;
      d_valid <= 1'b0;
    end else begin
      state_q <= state_d;
      pc      <= pc_d;
      d_valid <= valid_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_icode   <= 4'h1;
      d_ifun    <= 4'h0;
      d_ra      <= 4'hF;
      d_rb      <= 4'hF;
      d_valc    <= 32'h0;
      d_valp    <= 32'h0;
      d_pred_pc <= 32'h0;
    end else if (load_fd) begin
      d_icode   <= icode;
      d_ifun    <= ifun;
      d_ra      <= ra;
      d_rb      <= rb;
      d_valc    <= valc;
      d_valp    <= valp;
      d_pred_pc <= pred_pc;
    end
  end

  assign f_state = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//   Directed scenarios plus a randomized run against a byte-level model of
//   the fetch rules.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic [47:0] inst;
  logic        stall, redirect;
  logic [31:0] redirect_pc;
  logic        d_valid;
  logic [3:0]  d_icode, d_ifun, d_ra, d_rb;
  logic [31:0] d_valc, d_valp, d_pred_pc;
  logic [1:0]  f_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] rom [256];

  always #5 clk = ~clk;

  // ROM indexed by the low address byte, wrapping within 256 bytes.
  assign inst = {rom[pc[7:0]],            rom[8'(pc[7:0] + 8'd1)],
                 rom[8'(pc[7:0] + 8'd2)], rom[8'(pc[7:0] + 8'd3)],
                 rom[8'(pc[7:0] + 8'd4)], rom[8'(pc[7:0] + 8'd5)]};

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .pc(pc), .inst(inst), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .d_valid(d_valid),
    .d_icode(d_icode), .d_ifun(d_ifun), .d_ra(d_ra), .d_rb(d_rb),
    .d_valc(d_valc), .d_valp(d_valp), .d_pred_pc(d_pred_pc),
    .f_state(f_state)
  );

  // ---------------- reference model ----------------
  // Instruction length per opcode; 0 marks an invalid opcode.
  int len_tab [16] = '{1, 1, 2, 6, 6, 6, 2, 5, 5, 1, 2, 2, 0, 0, 0, 0};

  logic [31:0] m_pc;
  logic        m_valid;
  int          m_state;   // 0 RUN, 1 HALTED, 2 ERROR
  logic [3:0]  m_ic, m_fn, m_ra, m_rb;
  logic [31:0] m_vc, m_vp, m_pp;

  function automatic logic [7:0] rb_at(input logic [31:0] a, input int k);
    logic [7:0] idx;
    idx = 8'(a[7:0] + 8'(k));
    return rom[idx];
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_valid = 1'b0; m_state = 0;
    m_ic = 4'h1; m_fn = 4'h0; m_ra = 4'hF; m_rb = 4'hF;
    m_vc = 0; m_vp = 0; m_pp = 0;
  endtask

  // Apply one rising edge to the model using the current inputs.
  task automatic model_edge();
    int ic, n;
    int base;
    if (redirect) begin
      m_pc = redirect_pc; m_valid = 1'b0; m_state = 0;
    end else if (stall) begin
      // everything holds
    end else if (m_state != 0) begin
      m_valid = 1'b0;
    end else begin
      ic   = int'(rb_at(m_pc, 0) >> 4);
      n    = len_tab[ic];
      m_ic = 4'(ic);
      m_fn = rb_at(m_pc, 0) & 8'h0F;
      m_valid = 1'b1;
      if (ic inside {2, 3, 4, 5, 6, 10, 11}) begin
        m_ra = rb_at(m_pc, 1) >> 4;
        m_rb = rb_at(m_pc, 1) & 8'h0F;
      end else begin
        m_ra = 4'hF; m_rb = 4'hF;
      end
      base = (ic inside {3, 4, 5}) ? 2 : 1;
      if (ic inside {3, 4, 5, 7, 8})
        m_vc = rb_at(m_pc, base) + (rb_at(m_pc, base + 1) << 8) +
               (rb_at(m_pc, base + 2) << 16) + (32'(rb_at(m_pc, base + 3)) << 24);
      else
        m_vc = 0;
      m_vp = m_pc + 32'(n == 0 ? 1 : n);
      m_pp = (ic == 7 || ic == 8) ? m_vc : m_vp;
      if (n == 0)       m_state = 2;
      else if (ic == 0) m_state = 1;
      else              m_pc = m_pp;
    end
  endtask

  // One rising edge, then settle for sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    #2 rst = 1'b1;
  endtask

  task automatic go_to(input logic [31:0] a);
    redirect = 1'b1; redirect_pc = a; stall = 1'b0;
    tick();
    redirect = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h55;
    tick();
    #2 rst = 1'b0;
    #1;
    if (pc !== 32'h0)       begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
    n_checks++;
    if (d_valid !== 1'b0)   begin n_fail++; $display("FAIL reset_valid: got %b want 0", d_valid); end
    n_checks++;
    if (f_state !== 2'b00)  begin n_fail++; $display("FAIL reset_state: got %b want 00", f_state); end
    n_checks++;
    if ({d_icode, d_ifun, d_ra, d_rb} !== 16'h10FF)
      begin n_fail++; $display("FAIL reset_fields: got %h want 10ff", {d_icode, d_ifun, d_ra, d_rb}); end
    n_checks++;
    if ({d_valc, d_valp, d_pred_pc} !== 96'h0)
      begin n_fail++; $display("FAIL reset_words: got %h want 0", {d_valc, d_valp, d_pred_pc}); end
    n_checks++;
    stall = 1'b0; redirect = 1'b0;
    #1 rst = 1'b1;
  endtask

  task automatic test_sequential();
    rom[0] = 8'h30; rom[1] = 8'hF2; rom[2] = 8'h04; rom[3] = 8'h00;
    rom[4] = 8'h00; rom[5] = 8'h00; rom[6] = 8'h60; rom[7] = 8'h20;
    tick();
    if (d_valid !== 1'b1 || d_icode !== 4'h3 || d_ra !== 4'hF || d_rb !== 4'h2)
      begin n_fail++; $display("FAIL seq1_fields: got v%b ic%h ra%h rb%h want v1 ic3 raf rb2", d_valid, d_icode, d_ra, d_rb); end
    n_checks++;
    if (d_valc !== 32'h4 || d_valp !== 32'h6 || pc !== 32'h6)
      begin n_fail++; $display("FAIL seq1_words: got valc%h valp%h pc%h want 4 6 6", d_valc, d_valp, pc); end
    n_checks++;
    tick();
    if (d_valid !== 1'b1 || d_icode !== 4'h6 || d_ra !== 4'h2 || d_rb !== 4'h0 || d_valp !== 32'h8)
      begin n_fail++; $display("FAIL seq2: got v%b ic%h ra%h rb%h valp%h want v1 ic6 ra2 rb0 valp8", d_valid, d_icode, d_ra, d_rb, d_valp); end
    n_checks++;
  endtask

  task automatic test_jump();
    rom[8'h10] = 8'h70; rom[8'h11] = 8'h20; rom[8'h12] = 8'h00;
    rom[8'h13] = 8'h00; rom[8'h14] = 8'h00;
    go_to(32'h10);
    tick();
    if (d_valc !== 32'h20 || d_valp !== 32'h15 || d_pred_pc !== 32'h20)
      begin n_fail++; $display("FAIL jump_words: got valc%h valp%h pred%h want 20 15 20", d_valc, d_valp, d_pred_pc); end
    n_checks++;
    if (pc !== 32'h20) begin n_fail++; $display("FAIL jump_pc: got %h want 20", pc); end
    n_checks++;
  endtask

  task automatic test_redirect_precedence();
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    if (pc !== 32'h40 || d_valid !== 1'b0 || f_state !== 2'b00)
      begin n_fail++; $display("FAIL redirect_prec: got pc%h v%b st%b want 40 0 00", pc, d_valid, f_state); end
    n_checks++;
    // Stall alone must freeze pc and valid.
    redirect = 1'b0;
    tick(); tick();
    if (pc !== 32'h40 || d_valid !== 1'b0)
      begin n_fail++; $display("FAIL stall_hold: got pc%h v%b want 40 0", pc, d_valid); end
    n_checks++;
    stall = 1'b0;
  endtask

  task automatic test_halt();
    rom[8'h08] = 8'h00;
    go_to(32'h08);
    tick();
    if (d_valid !== 1'b1 || d_icode !== 4'h0 || f_state !== 2'b01 || pc !== 32'h8)
      begin n_fail++; $display("FAIL halt_capture: got v%b ic%h st%b pc%h want 1 0 01 8", d_valid, d_icode, f_state, pc); end
    n_checks++;
    tick(); tick();
    if (d_valid !== 1'b0 || f_state !== 2'b01 || pc !== 32'h8)
      begin n_fail++; $display("FAIL halt_hold: got v%b st%b pc%h want 0 01 8", d_valid, f_state, pc); end
    n_checks++;
    go_to(32'h0);
    if (pc !== 32'h0 || f_state !== 2'b00 || d_valid !== 1'b0)
      begin n_fail++; $display("FAIL halt_resume: got pc%h st%b v%b want 0 00 0", pc, f_state, d_valid); end
    n_checks++;
    tick();
    if (d_valid !== 1'b1 || d_icode !== 4'h3 || pc !== 32'h6)
      begin n_fail++; $display("FAIL halt_refetch: got v%b ic%h pc%h want 1 3 6", d_valid, d_icode, pc); end
    n_checks++;
  endtask

  task automatic test_invalid_reset();
    rom[8'h30] = 8'hE0;
    go_to(32'h30);
    tick();
    if (f_state !== 2'b10 || pc !== 32'h30 || d_valid !== 1'b1 || d_icode !== 4'hE)
      begin n_fail++; $display("FAIL invalid: got st%b pc%h v%b ic%h want 10 30 1 e", f_state, pc, d_valid, d_icode); end
    n_checks++;
    #2 rst = 1'b0;
    #1;
    if (pc !== 32'h0 || d_valid !== 1'b0 || f_state !== 2'b00)
      begin n_fail++; $display("FAIL async_reset: got pc%h v%b st%b want 0 0 00", pc, d_valid, f_state); end
    n_checks++;
    #1 rst = 1'b1;
    tick();
    if (d_valid !== 1'b1 || d_icode !== 4'h3 || pc !== 32'h6)
      begin n_fail++; $display("FAIL post_reset_fetch: got v%b ic%h pc%h want 1 3 6", d_valid, d_icode, pc); end
    n_checks++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    stall = 1'b0; redirect = 1'b0;
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      stall    = ($urandom_range(0, 3) == 0);
      redirect = ($urandom_range(0, 6) == 0);
      case ($urandom_range(0, 3))
        0:       redirect_pc = 32'hFFFF_FFFA + 32'($urandom_range(0, 5));
        default: redirect_pc = {24'h0, 8'($urandom)};
      endcase
      model_edge();
      tick();
      if (pc !== m_pc || d_valid !== m_valid || f_state !== 2'(m_state))
        begin n_fail++; $display("FAIL rand_ctl[%0d]: got pc%h v%b st%b want pc%h v%b st%0d", cyc, pc, d_valid, f_state, m_pc, m_valid, m_state); end
      n_checks++;
      if (m_valid) begin
        if ({d_icode, d_ifun, d_ra, d_rb} !== {m_ic, m_fn, m_ra, m_rb} ||
            d_valc !== m_vc || d_valp !== m_vp || d_pred_pc !== m_pp)
          begin n_fail++; $display("FAIL rand_fd[%0d]: got %h %h %h %h want %h %h %h %h", cyc, {d_icode, d_ifun, d_ra, d_rb}, d_valc, d_valp, d_pred_pc, {m_ic, m_fn, m_ra, m_rb}, m_vc, m_vp, m_pp); end
        n_checks++;
      end
    end
    stall = 1'b0; redirect = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'h10;
    rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    #12 rst = 1'b1;
    test_reset();
    test_sequential();
    test_jump();
    test_redirect_precedence();
    test_halt();
    test_invalid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
